bs_arb_rtr_bp: RTL and testbench

Parametrised successor to the bus driver `bs_gnrtr_n_rbtr`. It arbitrates among DRVRS device FIFOs, pops one packet at a time, and routes it by the destination ID in the packet's MSBs to one device or, for broadcast, to all devices except the source. New relative to the current bus driver:
- selectable round-robin or fixed-priority arbitration;
- per-device backpressure (`full`);
- invalid-destination dropping;
- packet and drop counters.

It sits between the per-device FIFOs and the device push ports.

---
 rtl/bs_arb_pkg.sv | 50 +++++
 rtl/bs_rr_arbiter.sv | 45 ++++
 rtl/bs_arb_rtr_bp.sv | 140 ++++++++++++++
 tb/tb_bs_arb_rtr_bp.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bs_arb_pkg.sv
// rtl/bs_arb_pkg.sv - shared types and helpers for the bus arbiter/router
// Contents:
//   state_t            router FSM states
//   ARB_RR, ARB_FIXED  arbitration mode encodings
//   get_dest(...)      destination field extraction from a packet
//   tgt_mask(...)      target device mask plus validity for a destination
package bs_arb_pkg;

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   localparam logic ARB_RR    = 1'b0;
   localparam logic ARB_FIXED = 1'b1;

   // Upper bounds for the helpers; callers zero-extend into these widths,
   // so PCKG_SZ <= PKT_MAX, ID_W <= ID_MAX and DRVRS <= DRV_MAX must hold.
   localparam int PKT_MAX = 256;
   localparam int ID_MAX  = 16;
   localparam int DRV_MAX = 64;

   typedef struct packed {
      logic               valid;
      logic [DRV_MAX-1:0] mask;
   } tgt_t;

   // Destination sits in the top id_w bits of a pckg_sz-bit packet.
   function automatic logic [ID_MAX-1:0] get_dest(input logic [PKT_MAX-1:0] pkt,
                                                  input int pckg_sz, input int id_w);
      logic [PKT_MAX-1:0] sh;
      logic [ID_MAX-1:0]  fmask;
      sh    = pkt >> (pckg_sz - id_w);
      fmask = (ID_MAX'(1) << id_w) - ID_MAX'(1);
      return sh[ID_MAX-1:0] & fmask;
   endfunction

   // Broadcast reaches every device except the source; a unicast below
   // drvrs (self included) reaches that device; anything else is invalid.
   function automatic tgt_t tgt_mask(input logic [ID_MAX-1:0] dest, input int src,
                                     input int drvrs, input logic [ID_MAX-1:0] bcast);
      tgt_t t;
      t.valid = 1'b1;
      t.mask  = '0;
      for (int i = 0; i < DRV_MAX; i++) begin
         if (dest == bcast) t.mask[i] = (i < drvrs) && (i != src);
         else               t.mask[i] = (int'(dest) == i);
      end
      if (dest != bcast && int'(dest) >= drvrs) t.valid = 1'b0;
      return t;
   endfunction

endpackage

// File: rtl/bs_rr_arbiter.sv
// rtl/bs_rr_arbiter.sv - combinational round-robin / fixed-priority picker
// Ports:
//   req      in   N   request vector
//   last_g   in   IW  index granted last time (round-robin pointer)
//   mode     in   1   ARB_RR or ARB_FIXED
//   gnt      out  IW  granted index
//   gnt_vld  out  1   any request present
module bs_rr_arbiter
   import bs_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_g,
   input  logic          mode,
   output logic [IW-1:0] gnt,
   output logic          gnt_vld
);

   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      if (mode == ARB_FIXED) begin
         // Highest index first so the lowest requester is the final writer.
         for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
               gnt     = IW'(i);
               gnt_vld = 1'b1;
            end
         end
      end else begin
         // Offsets farthest-first so the nearest requester after last_g wins.
         for (int k = N; k >= 1; k--) begin
            for (int j = 0; j < N; j++) begin
               if (req[j] && (j == (int'(last_g) + k) % N)) begin
                  gnt     = IW'(j);
                  gnt_vld = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/bs_arb_rtr_bp.sv
// rtl/bs_arb_rtr_bp.sv - bus arbiter/router with backpressure and counters
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   pndng       in   DRVRS          device FIFO non-empty
//   D_pop       in   DRVRS*PCKG_SZ  FIFO head data (first-word-fall-through)
//   full        in   DRVRS          device cannot accept a push
//   pop         out  DRVRS          one-cycle FIFO pop strobe
//   push        out  DRVRS          one-cycle device push strobe
//   D_push      out  DRVRS*PCKG_SZ  data presented with push
//   pkt_cnt     out  16             delivered packets (saturating)
//   drop_cnt    out  16             dropped packets (saturating)
module bs_arb_rtr_bp
   import bs_arb_pkg::*;
#(
   parameter int              PCKG_SZ  = 16,
   parameter int              DRVRS    = 4,
   parameter int              ID_W     = 8,
   parameter logic [ID_W-1:0] BCAST    = {ID_W{1'b1}},
   parameter int              ARB_MODE = 0
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [DRVRS-1:0]                pndng,
   input  logic [DRVRS-1:0][PCKG_SZ-1:0]   D_pop,
   input  logic [DRVRS-1:0]                full,
   output logic [DRVRS-1:0]                pop,
   output logic [DRVRS-1:0]                push,
   output logic [DRVRS-1:0][PCKG_SZ-1:0]   D_push,
   output logic [15:0]                     pkt_cnt,
   output logic [15:0]                     drop_cnt
);

   localparam int   GW   = $clog2(DRVRS);
   localparam logic MODE = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;

   state_t                           state_q, state_d;
   logic [GW-1:0]                    last_g_q, last_g_d;
   logic [PCKG_SZ-1:0]               pkt_q, pkt_d;
   logic [DRVRS-1:0]                 mask_q, mask_d;
   logic                             vld_q, vld_d;
   logic [DRVRS-1:0]                 pop_q, pop_d, push_q, push_d;
   logic [DRVRS-1:0][PCKG_SZ-1:0]    d_push_q, d_push_d;
   logic [15:0]                      pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;

   logic [GW-1:0]      gnt;
   logic               gnt_vld;
   logic [PCKG_SZ-1:0] sel_pkt;
   logic [ID_MAX-1:0]  dest;
   tgt_t               tgt;
   logic               unused_tgt_bits;

   bs_rr_arbiter #(.N(DRVRS), .IW(GW)) u_arb (
      .req     (pndng),
      .last_g  (last_g_q),
      .mode    (MODE),
      .gnt     (gnt),
      .gnt_vld (gnt_vld)
   );

   // The target mask is resolved at grant time, so the source index never
   // needs its own register: it is folded into mask_q.
   assign sel_pkt         = D_pop[gnt];
   assign dest            = get_dest(PKT_MAX'(sel_pkt), PCKG_SZ, ID_W);
   assign tgt             = tgt_mask(dest, int'(gnt), DRVRS, ID_MAX'(BCAST));
   assign unused_tgt_bits = ^tgt.mask;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         last_g_q   <= GW'(DRVRS - 1);
         pkt_q      <= '0;
         mask_q     <= '0;
         vld_q      <= 1'b0;
         pop_q      <= '0;
         push_q     <= '0;
         d_push_q   <= '0;
         pkt_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         last_g_q   <= last_g_d;
         pkt_q      <= pkt_d;
         mask_q     <= mask_d;
         vld_q      <= vld_d;
         pop_q      <= pop_d;
         push_q     <= push_d;
         d_push_q   <= d_push_d;
         pkt_cnt_q  <= pkt_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (gnt_vld) state_d = WAIT;
         WAIT:    if (!vld_q || ((mask_q & full) == '0)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      last_g_d   = last_g_q;
      pkt_d      = pkt_q;
      mask_d     = mask_q;
      vld_d      = vld_q;
      pop_d      = '0;
      push_d     = '0;
      d_push_d   = d_push_q;
      pkt_cnt_d  = pkt_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (state_q == IDLE) begin
         if (gnt_vld) begin
            pop_d    = DRVRS'(1) << gnt;
            last_g_d = gnt;
            pkt_d    = sel_pkt;
            mask_d   = tgt.mask[DRVRS-1:0];
            vld_d    = tgt.valid;
         end
      end else begin
         if (!vld_q) begin
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
         end else if ((mask_q & full) == '0) begin
            // All-or-nothing: a broadcast waits until every target is free.
            push_d = mask_q;
            for (int i = 0; i < DRVRS; i++) begin
               if (mask_q[i]) d_push_d[i] = pkt_q;
            end
            if (pkt_cnt_q != 16'hFFFF) pkt_cnt_d = pkt_cnt_q + 16'd1;
         end
      end
   end

   assign pop      = pop_q;
   assign push     = push_q;
   assign D_push   = d_push_q;
   assign pkt_cnt  = pkt_cnt_q;
   assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bs_arb_rtr_bp.sv
// tb/tb_bs_arb_rtr_bp.sv - scoreboard bench for bs_arb_rtr_bp
module tb_bs_arb_rtr_bp;

   localparam int PW = 16;
   localparam int N  = 4;
   localparam int IW = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]         pndng, full;
   logic [N-1:0][PW-1:0] D_pop;
   logic [N-1:0]         pop_r, push_r, pop_f, push_f;
   logic [N-1:0][PW-1:0] dpush_r, dpush_f;
   logic [15:0]          pc_r, dc_r, pc_f, dc_f;

   bs_arb_rtr_bp #(.PCKG_SZ(PW), .DRVRS(N), .ID_W(IW), .ARB_MODE(0)) u_rr (
      .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .full(full),
      .pop(pop_r), .push(push_r), .D_push(dpush_r), .pkt_cnt(pc_r), .drop_cnt(dc_r));

   bs_arb_rtr_bp #(.PCKG_SZ(PW), .DRVRS(N), .ID_W(IW), .ARB_MODE(1)) u_fix (
      .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .full(full),
      .pop(pop_f), .push(push_f), .D_push(dpush_f), .pkt_cnt(pc_f), .drop_cnt(dc_f));

   typedef struct {
      logic          drop;
      logic [N-1:0]  mask;
      logic [PW-1:0] pkt;
      int            pedge;
   } exp_t;

   exp_t                 sb[$];
   logic [PW-1:0]        fifo[N][$];
   int                   glog[$];
   logic [N-1:0][PW-1:0] dmodel = '0;
   logic [N-1:0]         full_at = '0;
   int passed = 0, total = 0;
   int edge_n = 0, last_g = N - 1;
   int exp_pc = 0, exp_dc = 0;
   logic fix_chk = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
   endtask

   // Reference routing rule from the packet's destination byte.
   function automatic exp_t model_pkt(input logic [PW-1:0] p, input int src);
      exp_t e;
      int   dest;
      dest    = int'(p[PW-1 -: IW]);
      e.pkt   = p;
      e.drop  = 1'b0;
      e.mask  = '0;
      e.pedge = 0;
      if (dest == 255)    e.mask = N'(((1 << N) - 1) & ~(1 << src));
      else if (dest < N)  e.mask = N'(1 << dest);
      else                e.drop = 1'b1;
      return e;
   endfunction

   function automatic int rr_winner(input logic [N-1:0] req);
      for (int k = 1; k <= N; k++) begin
         if (req[(last_g + k) % N]) return (last_g + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] lowest(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return N'(1 << i);
      return '0;
   endfunction

   function automatic logic [PW-1:0] rnd_pkt();
      int r;
      logic [7:0] d;
      r = $urandom_range(0, 9);
      if (r < 6)      d = 8'($urandom_range(0, N - 1));
      else if (r < 8) d = 8'hFF;
      else            d = 8'($urandom_range(N, 254));
      return {d, 8'($urandom)};
   endfunction

   task automatic drive_fifo();
      for (int i = 0; i < N; i++) begin
         pndng[i] = (fifo[i].size() > 0);
         D_pop[i] = (fifo[i].size() > 0) ? fifo[i][0] : '0;
      end
   endtask

   task automatic put(input int dev, input logic [PW-1:0] p);
      fifo[dev].push_back(p);
      drive_fifo();
   endtask

   // One clock: check the pop decision made from the inputs held at this edge.
   task automatic step();
      logic [N-1:0] pn, ep;
      int g;
      exp_t e;
      pn = pndng;
      @(posedge clk);
      #1;
      if (!reset) begin
         g = (sb.size() == 0 && pn != '0) ? rr_winner(pn) : -1;
         ep = (g >= 0) ? N'(1 << g) : '0;
         chk("pop", 64'(pop_r), 64'(ep));
         if (fix_chk) chk("pop_fixed", 64'(pop_f), 64'((g >= 0) ? lowest(pn) : '0));
         if (g >= 0) begin
            last_g  = g;
            e       = model_pkt(fifo[g][0], g);
            e.pedge = edge_n;
            sb.push_back(e);
            glog.push_back(g);
            void'(fifo[g].pop_front());
         end
      end
      drive_fifo();
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_pop", 64'(pop_r), 64'(0));
      chk("rst_push", 64'(push_r), 64'(0));
      chk("rst_dpush", 64'(dpush_r), 64'(0));
      chk("rst_pkt_cnt", 64'(pc_r), 64'(0));
      chk("rst_drop_cnt", 64'(dc_r), 64'(0));
      sb.delete();
      glog.delete();
      for (int i = 0; i < N; i++) fifo[i].delete();
      last_g = N - 1;
      exp_pc = 0;
      exp_dc = 0;
      dmodel = '0;
      full   = '0;
      drive_fifo();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Edge bookkeeping: edge index and the full vector the DUT sampled.
   initial forever begin
      @(posedge clk);
      edge_n++;
      full_at = full;
   end

   // Delivery monitor: each later edge resolves the oldest in-flight packet.
   initial forever begin
      logic [N-1:0] ep;
      @(negedge clk);
      if (!reset) begin
         ep = '0;
         if (sb.size() > 0 && sb[0].pedge < edge_n) begin
            if (sb[0].drop) begin
               exp_dc++;
               void'(sb.pop_front());
            end else if ((sb[0].mask & full_at) == '0) begin
               ep = sb[0].mask;
               for (int i = 0; i < N; i++) if (ep[i]) dmodel[i] = sb[0].pkt;
               exp_pc++;
               void'(sb.pop_front());
            end
         end
         chk("push", 64'(push_r), 64'(ep));
         chk("d_push", 64'(dpush_r), 64'(dmodel));
         chk("pkt_cnt", 64'(pc_r), 64'(exp_pc[15:0]));
         chk("drop_cnt", 64'(dc_r), 64'(exp_dc[15:0]));
      end
   end

   task automatic run_random(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         if ($urandom_range(0, 2) == 0) put($urandom_range(0, N - 1), rnd_pkt());
         full = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         step();
      end
   endtask

   initial begin
      int n;
      full = '0;
      drive_fifo();
      do_reset();

      // Unicast to device 2, then broadcast from 0, then invalid destination.
      put(1, 16'h02AB); step(); step(); step();
      put(0, 16'hFF55); step(); step(); step();
      put(2, 16'h0712); step(); step(); step();

      // Device 3 held full for five sampled edges; device 1 must not be popped meanwhile.
      full = 4'b1000;
      put(0, 16'h0399); step();
      put(1, 16'h0055);
      repeat (5) step();
      full = '0;
      repeat (4) step();

      run_random(1500);
      do_reset();

      // All requesters busy from reset: round-robin order and fixed-priority winner.
      fix_chk = 1'b1;
      for (int i = 0; i < N; i++) for (int j = 0; j < 4; j++) put(i, {8'($urandom_range(0, N - 1)), 8'($urandom)});
      repeat (10) step();
      fix_chk = 1'b0;
      chk("grant_count", 64'(glog.size()), 64'(5));
      for (int i = 0; i < 5 && i < glog.size(); i++) chk("grant_order", 64'(glog[i]), 64'(i % N));

      run_random(3000);
      full = '0;
      n = 0;
      while (n < 2000 && (sb.size() > 0 || pndng != '0)) begin
         step();
         n++;
      end
      chk("drained", 64'((sb.size() == 0 && pndng == '0) ? 1 : 0), 64'(1));
      repeat (2) step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
